spi_boot_loader: RTL

- SPI-slave receive path plus loader between the board SPI pins and the SoC instruction memory.
- Synchronises the external SPI lines (mode 0, MSB-first), assembles bytes into little-endian 32-bit words and writes them sequentially into instruction RAM from word 0.
- Holds the CPU in reset until a clean frame is loaded, then releases it.

---
 rtl/boot_pkg.sv | 6 +
 rtl/spi_slave_rx.sv | 63 ++++++
 rtl/spi_boot_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and sizing constants for the SPI boot loader.
package boot_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} boot_state_t;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_BITS  = 8;
endpackage

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive front end: synchronisers, sck/cs edge detect, MSB-first byte shifter.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sck,
  input  logic       i_mosi,
  input  logic       i_cs,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_cs_fall,
  output logic       o_cs_rise,
  output logic       o_cs_active,
  output logic       o_bit_pend
);
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync, r_flush;
  logic                   r_sck_prev, r_cs_prev;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic                   w_sck, w_mosi, w_cs_hi, w_flushed, w_sck_rise;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_hi    = r_cs_sync[SYNC_STAGES-1];
  assign w_flushed  = r_flush[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;

  // cs edges only count once the chain holds real pin samples, so a frame
  // already in progress when reset is released never looks like a fresh start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_flush     <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_flushed & w_cs_hi;
      if (w_cs_hi) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {r_shift[5:0], w_mosi};
      end
    end
  end

  assign o_byte_valid = w_sck_rise & ~w_cs_hi & (r_bit_cnt == 3'd7);
  assign o_byte_data  = {r_shift, w_mosi};
  assign o_cs_fall    = r_cs_prev & ~w_cs_hi;
  assign o_cs_rise    = w_flushed & ~r_cs_prev & w_cs_hi;
  assign o_cs_active  = ~w_cs_hi;
  assign o_bit_pend   = (r_bit_cnt != 3'd0);
endmodule

// File: rtl/spi_boot_loader.sv
// Loads little-endian words from an SPI frame into instruction RAM and
// releases the CPU from reset only after a clean, complete frame.
module spi_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int MEM_WORDS   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   word_cnt
);
  import boot_pkg::*;

  localparam logic [ADDR_W:0] LP_MAX = (ADDR_W+1)'(MEM_WORDS);

  boot_state_t r_state, w_next_state;
  logic        w_start, w_check_ok, w_cpu_rst_n;
  logic [ADDR_W:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [(WORD_BYTES-1)*BYTE_BITS-1:0] r_buf;
  logic        r_ovf, r_partial, r_done, r_err, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_byte_valid, w_cs_fall, w_cs_rise, w_cs_active, w_bit_pend;
  logic [7:0]  w_byte;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sck        (spi_sck),
    .i_mosi       (spi_mosi),
    .i_cs         (spi_cs),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte),
    .o_cs_fall    (w_cs_fall),
    .o_cs_rise    (w_cs_rise),
    .o_cs_active  (w_cs_active),
    .o_bit_pend   (w_bit_pend)
  );

  assign w_check_ok = !r_ovf && !r_partial && (r_word_idx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // The CPU reset is dropped combinationally on a re-flash cs fall so the
  // core is never running while its memory is being overwritten.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_cpu_rst_n  = 1'b0;
    case (r_state)
      IDLE:  if (w_cs_fall) begin w_next_state = LOAD; w_start = 1'b1; end
      LOAD:  if (w_cs_rise) w_next_state = CHECK;
      CHECK: w_next_state = w_check_ok ? RUN : IDLE;
      RUN: begin
        w_cpu_rst_n = 1'b1;
        if (w_cs_fall) begin
          w_next_state = LOAD;
          w_start      = 1'b1;
          w_cpu_rst_n  = 1'b0;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_ovf      <= 1'b0;
      r_partial  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_ovf      <= 1'b0;
        r_partial  <= 1'b0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end
      if (r_state == LOAD) begin
        if (w_byte_valid && w_cs_active) begin
          r_byte_idx <= r_byte_idx + 2'd1;
          if (r_byte_idx == 2'(WORD_BYTES-1)) begin
            if (r_word_idx < LP_MAX) begin
              r_we       <= 1'b1;
              r_addr     <= r_word_idx[ADDR_W-1:0];
              r_wdata    <= {w_byte, r_buf};
              r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end
        if (w_cs_rise) r_partial <= (r_byte_idx != 2'd0) || w_bit_pend;
      end
      if (r_state == CHECK) begin
        if (w_check_ok) r_done <= 1'b1;
        else            r_err  <= (r_word_idx != '0) || r_partial;
      end
    end
  end

  // Byte k lands in bits [8k+7:8k]; the buffer shifts right so byte 0 ends lowest.
  always_ff @(posedge clk) begin
    if (r_state == LOAD && w_byte_valid && w_cs_active)
      r_buf <= {w_byte, r_buf[(WORD_BYTES-1)*BYTE_BITS-1:BYTE_BITS]};
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rst_n = w_cpu_rst_n;
  assign boot_done = r_done;
  assign boot_err  = r_err;
  assign word_cnt  = r_word_idx;
endmodule
